// File: rtl/host_pkg.sv
// Shared definitions for the host sequencer: state encoding and the
// default values of the sequencer parameters.
`timescale 1ns/1ps
package host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DUMP  = 3'd4,
        ST_DONE  = 3'd5
    } host_state_e;

    localparam int unsigned START_CYCLES_DEF = 2;
    localparam logic [15:0] MAX_CYCLES_DEF   = 16'hFFFF;
    localparam logic [7:0]  DUMP_BASE_DEF    = 8'h00;
    localparam logic [7:0]  DUMP_LEN_DEF     = 8'd16;

endpackage

// File: rtl/host_sequencer_run_timer.sv
// RUN-phase cycle counter with saturating timeout compare.
// The counter is cleared by the sequencer when a new sequence is accepted,
// counts every RUN cycle the processor has not halted, and stops at
// MAX_CYCLES. timeout_o flags the RUN cycle in which the limit has been
// reached without a halt.
`timescale 1ns/1ps
module run_timer
    import host_pkg::*;
#(
    parameter logic [15:0] MAX_CYCLES = MAX_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        run_i,
    input  logic        halt_i,
    output logic [15:0] count_o,
    output logic        timeout_o
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Next count: clear on a new sequence, otherwise count non-halted RUN cycles up to the limit
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (run_i && !halt_i && (count_q != MAX_CYCLES)) begin
            count_d = count_q + 16'd1;
        end
    end

    // Count register, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    // A halt in the same cycle takes priority over the timeout
    assign timeout_o = run_i && !halt_i && (count_q == MAX_CYCLES);

endmodule

// File: rtl/host_sequencer.sv
// Host-side load/run/dump sequencer for a small processor under test.
// Preloads data memory from a beat stream, pulses the processor init line,
// times the run until halt (or timeout), then streams a window of data
// memory back out over a valid/ready interface.
`timescale 1ns/1ps
module host_sequencer
    import host_pkg::*;
#(
    parameter int unsigned START_CYCLES = START_CYCLES_DEF,
    parameter logic [15:0] MAX_CYCLES   = MAX_CYCLES_DEF,
    parameter logic [7:0]  DUMP_BASE    = DUMP_BASE_DEF,
    parameter logic [7:0]  DUMP_LEN     = DUMP_LEN_DEF
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        go,
    input  logic        pl_valid,
    input  logic        pl_last,
    input  logic [7:0]  pl_addr,
    input  logic [7:0]  pl_data,
    output logic        pl_ready,
    output logic        mem_wr_en,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wr_data,
    input  logic [7:0]  mem_rd_data,
    output logic        dut_start,
    input  logic        dut_halt,
    output logic        dump_valid,
    input  logic        dump_ready,
    output logic [7:0]  dump_data,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] cycle_count
);

    localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
    localparam logic [7:0]  DUMP_LAST  = DUMP_LEN - 8'd1;

    host_state_e state_q, state_d;
    logic [15:0] start_cnt_q, start_cnt_d;
    logic [7:0]  dump_idx_q, dump_idx_d;
    logic        done_q, done_d;
    logic        timeout_q, timeout_d;

    logic        go_accept;
    logic        run_active;
    logic        tmr_timeout;

    assign go_accept  = (state_q == ST_IDLE) && go;
    assign run_active = (state_q == ST_RUN);

    run_timer #(
        .MAX_CYCLES (MAX_CYCLES)
    ) u_run_timer (
        .clk_i     (CLK),
        .rst_ni    (reset),
        .clear_i   (go_accept),
        .run_i     (run_active),
        .halt_i    (dut_halt),
        .count_o   (cycle_count),
        .timeout_o (tmr_timeout)
    );

    // State register
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; go only matters in IDLE, and DONE waits for go to drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (go) state_d = ST_LOAD;
            ST_LOAD:  if (pl_valid && pl_last) state_d = ST_START;
            ST_START: if (start_cnt_q == START_LAST) state_d = ST_RUN;
            ST_RUN: begin
                if (dut_halt) begin
                    state_d = (DUMP_LEN == 8'd0) ? ST_DONE : ST_DUMP;
                end else if (tmr_timeout) begin
                    state_d = ST_DONE;
                end
            end
            ST_DUMP:  if (dump_ready && (dump_idx_q == DUMP_LAST)) state_d = ST_DONE;
            ST_DONE:  if (!go) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the current state
    always_comb begin
        busy        = 1'b0;
        pl_ready    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = 8'h00;
        mem_wr_data = 8'h00;
        dut_start   = 1'b1;
        dump_valid  = 1'b0;
        dump_data   = 8'h00;
        case (state_q)
            ST_LOAD: begin
                busy        = 1'b1;
                pl_ready    = 1'b1;
                mem_wr_en   = pl_valid;
                mem_addr    = pl_addr;
                mem_wr_data = pl_data;
            end
            ST_START: begin
                busy = 1'b1;
            end
            ST_RUN: begin
                busy      = 1'b1;
                dut_start = 1'b0;
            end
            ST_DUMP: begin
                busy       = 1'b1;
                dut_start  = 1'b0;
                dump_valid = 1'b1;
                mem_addr   = DUMP_BASE + dump_idx_q;
                dump_data  = mem_rd_data;
            end
            default: begin
            end
        endcase
    end

    // Next values of the START counter, dump index and sticky status flags
    always_comb begin
        start_cnt_d = (state_q == ST_START) ? (start_cnt_q + 16'd1) : 16'd0;
        dump_idx_d  = 8'd0;
        if (state_q == ST_DUMP) begin
            dump_idx_d = dump_ready ? (dump_idx_q + 8'd1) : dump_idx_q;
        end
        done_d    = done_q;
        timeout_d = timeout_q;
        if (go_accept) begin
            done_d    = 1'b0;
            timeout_d = 1'b0;
        end
        if ((state_q != ST_DONE) && (state_d == ST_DONE)) begin
            done_d = 1'b1;
        end
        if (run_active && tmr_timeout) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and status registers
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            start_cnt_q <= '0;
            dump_idx_q  <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            start_cnt_q <= start_cnt_d;
            dump_idx_q  <= dump_idx_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    assign done    = done_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_host_sequencer.sv
// Directed bench for host_sequencer: instance A (dump window 0xFE, length 4)
// covers load/start/run/dump/done/reset; instance B (MAX_CYCLES=20) covers
// the timeout path and the halt-vs-timeout tie.
`timescale 1ns/1ps
module tb_host_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset;
    logic        go_a, go_b;
    logic        pl_valid, pl_last;
    logic [7:0]  pl_addr, pl_data;
    logic        dump_ready;
    logic        halt_a, halt_b;

    logic        pl_ready_a, mem_wr_en_a, dut_start_a, dump_valid_a, busy_a, done_a, timeout_a;
    logic [7:0]  mem_addr_a, mem_wr_data_a, mem_rd_data_a, dump_data_a;
    logic [15:0] cycle_count_a;
    logic        pl_ready_b, mem_wr_en_b, dut_start_b, dump_valid_b, busy_b, done_b, timeout_b;
    logic [7:0]  mem_addr_b, mem_wr_data_b, mem_rd_data_b, dump_data_b;
    logic [15:0] cycle_count_b;

    int n_vec = 0;
    int n_bad = 0;

    // memory model: 0xFE..0x01 hold 1,2,3,4
    always_comb begin
        mem_rd_data_a = 8'h00;
        case (mem_addr_a)
            8'hFE: mem_rd_data_a = 8'd1;
            8'hFF: mem_rd_data_a = 8'd2;
            8'h00: mem_rd_data_a = 8'd3;
            8'h01: mem_rd_data_a = 8'd4;
            default: mem_rd_data_a = 8'h00;
        endcase
    end
    assign mem_rd_data_b = 8'h5A;

    host_sequencer #(.START_CYCLES(2), .MAX_CYCLES(16'hFFFF), .DUMP_BASE(8'hFE), .DUMP_LEN(8'd4)) dut_a (
        .CLK(CLK), .reset(reset), .go(go_a), .pl_valid(pl_valid), .pl_last(pl_last),
        .pl_addr(pl_addr), .pl_data(pl_data), .pl_ready(pl_ready_a), .mem_wr_en(mem_wr_en_a),
        .mem_addr(mem_addr_a), .mem_wr_data(mem_wr_data_a), .mem_rd_data(mem_rd_data_a),
        .dut_start(dut_start_a), .dut_halt(halt_a), .dump_valid(dump_valid_a),
        .dump_ready(dump_ready), .dump_data(dump_data_a), .busy(busy_a), .done(done_a),
        .timeout(timeout_a), .cycle_count(cycle_count_a));

    host_sequencer #(.START_CYCLES(2), .MAX_CYCLES(16'd20), .DUMP_BASE(8'hFE), .DUMP_LEN(8'd4)) dut_b (
        .CLK(CLK), .reset(reset), .go(go_b), .pl_valid(pl_valid), .pl_last(pl_last),
        .pl_addr(pl_addr), .pl_data(pl_data), .pl_ready(pl_ready_b), .mem_wr_en(mem_wr_en_b),
        .mem_addr(mem_addr_b), .mem_wr_data(mem_wr_data_b), .mem_rd_data(mem_rd_data_b),
        .dut_start(dut_start_b), .dut_halt(halt_b), .dump_valid(dump_valid_b),
        .dump_ready(dump_ready), .dump_data(dump_data_b), .busy(busy_b), .done(done_b),
        .timeout(timeout_b), .cycle_count(cycle_count_b));

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; go_a = 0; go_b = 0; pl_valid = 0; pl_last = 0; pl_addr = 0; pl_data = 0;
        dump_ready = 0; halt_a = 0; halt_b = 0;
        #2;
        n_vec++; if (dut_start_a !== 1'b1) begin n_bad++; $display("FAIL rst_dut_start_a: got %b want 1", dut_start_a); end
        n_vec++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_busy_a: got %b want 0", busy_a); end
        n_vec++; if ({done_a, timeout_a} !== 2'b00) begin n_bad++; $display("FAIL rst_done_timeout_a: got %b want 00", {done_a, timeout_a}); end
        n_vec++; if ({pl_ready_a, mem_wr_en_a, dump_valid_a} !== 3'b000) begin n_bad++; $display("FAIL rst_handshakes_a: got %b want 000", {pl_ready_a, mem_wr_en_a, dump_valid_a}); end
        n_vec++; if (cycle_count_a !== 16'd0) begin n_bad++; $display("FAIL rst_cycle_count_a: got %0d want 0", cycle_count_a); end
        n_vec++; if ({busy_b, done_b, timeout_b, dut_start_b} !== 4'b0001) begin n_bad++; $display("FAIL rst_status_b: got %b want 0001", {busy_b, done_b, timeout_b, dut_start_b}); end
        tick;
        reset = 1'b1;
        tick;
        n_vec++; if ({busy_a, pl_ready_a, dut_start_a} !== 3'b001) begin n_bad++; $display("FAIL idle_after_release: got %b want 001", {busy_a, pl_ready_a, dut_start_a}); end
    endtask

    task automatic test_load_start;
        logic [7:0] a_tab [3];
        logic [7:0] d_tab [3];
        a_tab = '{8'h10, 8'h11, 8'h12};
        d_tab = '{8'hAA, 8'hBB, 8'hCC};
        go_a = 1'b1;
        tick;
        go_a = 1'b0;
        #1;
        n_vec++; if ({pl_ready_a, busy_a, done_a} !== 3'b110) begin n_bad++; $display("FAIL load_entry: got %b want 110", {pl_ready_a, busy_a, done_a}); end
        n_vec++; if (mem_wr_en_a !== 1'b0) begin n_bad++; $display("FAIL load_no_valid_wr: got %b want 0", mem_wr_en_a); end
        tick;
        for (int i = 0; i < 3; i++) begin
            pl_valid = 1'b1; pl_addr = a_tab[i]; pl_data = d_tab[i]; pl_last = (i == 2);
            #1;
            n_vec++; if (mem_wr_en_a !== 1'b1) begin n_bad++; $display("FAIL load_wr_en[%0d]: got %b want 1", i, mem_wr_en_a); end
            n_vec++; if (mem_addr_a !== a_tab[i]) begin n_bad++; $display("FAIL load_addr[%0d]: got %h want %h", i, mem_addr_a, a_tab[i]); end
            n_vec++; if (mem_wr_data_a !== d_tab[i]) begin n_bad++; $display("FAIL load_data[%0d]: got %h want %h", i, mem_wr_data_a, d_tab[i]); end
            tick;
        end
        pl_valid = 1'b0; pl_last = 1'b0;
        #1;
        n_vec++; if ({dut_start_a, mem_wr_en_a, pl_ready_a, busy_a} !== 4'b1001) begin n_bad++; $display("FAIL start_cycle1: got %b want 1001", {dut_start_a, mem_wr_en_a, pl_ready_a, busy_a}); end
        tick;
        n_vec++; if (dut_start_a !== 1'b1) begin n_bad++; $display("FAIL start_cycle2: got %b want 1", dut_start_a); end
        tick;
        n_vec++; if (dut_start_a !== 1'b0) begin n_bad++; $display("FAIL start_released: got %b want 0", dut_start_a); end
        n_vec++; if (cycle_count_a !== 16'd0) begin n_bad++; $display("FAIL run_count_start: got %0d want 0", cycle_count_a); end
    endtask

    task automatic test_run_halt;
        for (int i = 0; i < 37; i++) tick;
        n_vec++; if (cycle_count_a !== 16'd37) begin n_bad++; $display("FAIL run_count_37: got %0d want 37", cycle_count_a); end
        n_vec++; if ({busy_a, dump_valid_a} !== 2'b10) begin n_bad++; $display("FAIL run_status: got %b want 10", {busy_a, dump_valid_a}); end
        halt_a = 1'b1;
        tick;
        halt_a = 1'b0;
        #1;
        n_vec++; if (dump_valid_a !== 1'b1) begin n_bad++; $display("FAIL halt_to_dump: got %b want 1", dump_valid_a); end
        n_vec++; if (cycle_count_a !== 16'd37) begin n_bad++; $display("FAIL halt_count: got %0d want 37", cycle_count_a); end
        n_vec++; if (timeout_a !== 1'b0) begin n_bad++; $display("FAIL halt_timeout: got %b want 0", timeout_a); end
    endtask

    task automatic test_dump;
        logic [7:0] a_tab [4];
        logic [7:0] d_tab [4];
        a_tab = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        d_tab = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int k = 0; k < 4; k++) begin
            dump_ready = 1'b0;
            #1;
            n_vec++; if (mem_addr_a !== a_tab[k]) begin n_bad++; $display("FAIL dump_addr[%0d]: got %h want %h", k, mem_addr_a, a_tab[k]); end
            n_vec++; if (dump_data_a !== d_tab[k]) begin n_bad++; $display("FAIL dump_data[%0d]: got %0d want %0d", k, dump_data_a, d_tab[k]); end
            tick;
            n_vec++; if ({dump_valid_a, mem_addr_a, dump_data_a} !== {1'b1, a_tab[k], d_tab[k]}) begin n_bad++; $display("FAIL dump_stall[%0d]: got %b/%h/%0d want 1/%h/%0d", k, dump_valid_a, mem_addr_a, dump_data_a, a_tab[k], d_tab[k]); end
            dump_ready = 1'b1;
            tick;
        end
        dump_ready = 1'b0;
        #1;
        n_vec++; if ({done_a, busy_a, dump_valid_a, dut_start_a} !== 4'b1001) begin n_bad++; $display("FAIL dump_to_done: got %b want 1001", {done_a, busy_a, dump_valid_a, dut_start_a}); end
        n_vec++; if ({timeout_a, cycle_count_a} !== {1'b0, 16'd37}) begin n_bad++; $display("FAIL done_counts: got %b/%0d want 0/37", timeout_a, cycle_count_a); end
    endtask

    task automatic test_go_held;
        go_a = 1'b1;
        tick; tick; tick;
        n_vec++; if ({done_a, busy_a, pl_ready_a} !== 3'b100) begin n_bad++; $display("FAIL go_held_no_restart: got %b want 100", {done_a, busy_a, pl_ready_a}); end
        go_a = 1'b0;
        tick;
        n_vec++; if ({busy_a, pl_ready_a, dut_start_a} !== 3'b001) begin n_bad++; $display("FAIL back_to_idle: got %b want 001", {busy_a, pl_ready_a, dut_start_a}); end
        go_a = 1'b1;
        tick;
        go_a = 1'b0;
        n_vec++; if ({pl_ready_a, busy_a, done_a, cycle_count_a} !== {3'b110, 16'd0}) begin n_bad++; $display("FAIL restart: got %b/%0d want 110/0", {pl_ready_a, busy_a, done_a}, cycle_count_a); end
    endtask

    task automatic test_reset_midrun;
        pl_valid = 1'b1; pl_last = 1'b1; pl_addr = 8'h20; pl_data = 8'h55;
        tick;
        pl_valid = 1'b0; pl_last = 1'b0;
        tick; tick;
        for (int i = 0; i < 10; i++) tick;
        n_vec++; if ({dut_start_a, cycle_count_a} !== {1'b0, 16'd10}) begin n_bad++; $display("FAIL midrun_count: got %b/%0d want 0/10", dut_start_a, cycle_count_a); end
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({dut_start_a, busy_a, done_a, timeout_a} !== 4'b1000) begin n_bad++; $display("FAIL async_rst_status: got %b want 1000", {dut_start_a, busy_a, done_a, timeout_a}); end
        n_vec++; if ({pl_ready_a, mem_wr_en_a, dump_valid_a, cycle_count_a} !== {3'b000, 16'd0}) begin n_bad++; $display("FAIL async_rst_outputs: got %b/%0d want 000/0", {pl_ready_a, mem_wr_en_a, dump_valid_a}, cycle_count_a); end
        tick;
        reset = 1'b1;
        tick;
        go_a = 1'b1;
        tick;
        go_a = 1'b0;
        n_vec++; if ({busy_a, pl_ready_a, cycle_count_a} !== {2'b11, 16'd0}) begin n_bad++; $display("FAIL clean_restart: got %b/%0d want 11/0", {busy_a, pl_ready_a}, cycle_count_a); end
        pl_valid = 1'b1; pl_last = 1'b1;
        tick;
        pl_valid = 1'b0; pl_last = 1'b0;
        tick; tick;
        for (int i = 0; i < 5; i++) tick;
        n_vec++; if (cycle_count_a !== 16'd5) begin n_bad++; $display("FAIL clean_run_count: got %0d want 5", cycle_count_a); end
        halt_a = 1'b1;
        tick;
        halt_a = 1'b0;
        dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        dump_ready = 1'b0;
        n_vec++; if ({done_a, dump_valid_a} !== 2'b10) begin n_bad++; $display("FAIL clean_dump_done: got %b want 10", {done_a, dump_valid_a}); end
        tick;
    endtask

    task automatic test_timeout;
        logic saw_dv;
        int   k;
        saw_dv = 1'b0;
        go_b = 1'b1;
        tick;
        go_b = 1'b0;
        pl_valid = 1'b1; pl_last = 1'b1; pl_addr = 8'h30; pl_data = 8'h77;
        tick;
        pl_valid = 1'b0; pl_last = 1'b0;
        tick; tick;
        n_vec++; if (dut_start_b !== 1'b0) begin n_bad++; $display("FAIL to_run_b: got %b want 0", dut_start_b); end
        for (k = 0; k < 40 && done_b !== 1'b1; k++) begin
            if (dump_valid_b === 1'b1) saw_dv = 1'b1;
            tick;
        end
        n_vec++; if (done_b !== 1'b1) begin n_bad++; $display("FAIL timeout_done: got %b want 1 after %0d cycles", done_b, k); end
        n_vec++; if ({timeout_b, cycle_count_b} !== {1'b1, 16'd20}) begin n_bad++; $display("FAIL timeout_count: got %b/%0d want 1/20", timeout_b, cycle_count_b); end
        n_vec++; if ({saw_dv, dump_valid_b, busy_b} !== 3'b000) begin n_bad++; $display("FAIL timeout_no_dump: got %b want 000", {saw_dv, dump_valid_b, busy_b}); end
        tick;
        go_b = 1'b1;
        tick;
        go_b = 1'b0;
        n_vec++; if ({timeout_b, done_b, cycle_count_b} !== {2'b00, 16'd0}) begin n_bad++; $display("FAIL go_clears_b: got %b/%0d want 00/0", {timeout_b, done_b}, cycle_count_b); end
    endtask

    task automatic test_halt_tie;
        int k;
        pl_valid = 1'b1; pl_last = 1'b1;
        tick;
        pl_valid = 1'b0; pl_last = 1'b0;
        tick; tick;
        for (k = 0; k < 30 && cycle_count_b !== 16'd20; k++) tick;
        n_vec++; if ({busy_b, cycle_count_b} !== {1'b1, 16'd20}) begin n_bad++; $display("FAIL tie_reach_max: got %b/%0d want 1/20", busy_b, cycle_count_b); end
        halt_b = 1'b1;
        tick;
        halt_b = 1'b0;
        n_vec++; if ({dump_valid_b, timeout_b} !== 2'b10) begin n_bad++; $display("FAIL tie_halt_wins: got %b want 10", {dump_valid_b, timeout_b}); end
        dump_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        dump_ready = 1'b0;
        n_vec++; if ({done_b, timeout_b} !== 2'b10) begin n_bad++; $display("FAIL tie_done: got %b want 10", {done_b, timeout_b}); end
    endtask

    initial begin
        test_reset;
        test_load_start;
        test_run_halt;
        test_dump;
        test_go_held;
        test_reset_midrun;
        test_timeout;
        test_halt_tie;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
